// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a single sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        mthiW,
  input  logic        mtloW,
  input  logic [31:0] wdataW,
  input  logic        mdreqD,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mdstallD,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic        sign_a, sign_b, is_div;

  logic [31:0] mag_a, mag_b;
  logic        neg_a, neg_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] acc_mul, acc_div, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign busy      = (state != IDLE);
  assign mdstallD  = mdreqD & (busy | startE);
  assign dbg_state = state;

  always_comb begin
    neg_a = opE[0] & srcaE[31];
    neg_b = opE[0] & srcbE[31];
    mag_a = neg_a ? (~srcaE + 32'd1) : srcaE;
    mag_b = neg_b ? (~srcbE + 32'd1) : srcbE;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    acc_mul   = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_div   = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                             : {div_diff[31:0], acc[30:0], 1'b1};
  end

  // A zero divisor leaves an all-ones quotient unnegated; the remainder returns the dividend.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    quo_fix  = ((sign_a ^ sign_b) && (opnd != 32'd0)) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (startE) state_next = opE[1] ? DIV : MUL;
      MUL:  if (cnt == 5'd31) state_next = FIX;
      DIV:  if (cnt == 5'd31) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 5'd0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: if (startE) begin
          cnt    <= 5'd0;
          sign_a <= neg_a;
          sign_b <= neg_b;
          is_div <= opE[1];
          opnd   <= opE[1] ? mag_b : mag_a;
          acc    <= {32'd0, (opE[1] ? mag_a : mag_b)};
        end
        MUL: begin
          acc <= acc_mul;
          cnt <= cnt + 5'd1;
        end
        DIV: begin
          acc <= acc_div;
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // The FIX write wins over a same-edge mthi/mtlo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == FIX) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[63:32];
        lo <= prod_fix[31:0];
      end
    end else begin
      if (mthiW) hi <= wdataW;
      if (mtloW) lo <= wdataW;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit results, latency, stall and HI/LO writes.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        mthiW, mtloW;
  logic [31:0] wdataW;
  logic        mdreqD;
  logic [31:0] hi, lo;
  logic        busy, mdstallD;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_exp = 64'd0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .mthiW(mthiW), .mtloW(mtloW),
    .wdataW(wdataW), .mdreqD(mdreqD), .hi(hi), .lo(lo),
    .busy(busy), .mdstallD(mdstallD), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check(tag, {hi, lo}, e);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    x = sa;
    y = sb;
    case (op)
      2'b00: return {32'd0, a} * {32'd0, b};
      2'b01: return x * y;
      2'b10: return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // mode 1: pulse startE mid-operation; 2: mtloW on the FIX edge; 3: mthiW mid-operation
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int mode, input string tag);
    int cyc;
    @(negedge clk);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    startE = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      startE = (mode == 1 && cyc == 5);
      if (mode == 1 && cyc == 5) begin
        opE = 2'b10; srcaE = 32'h55; srcbE = 32'h0;
      end
      mthiW = (mode == 3 && cyc == 10);
      mtloW = (mode == 2 && cyc == 32);
      wdataW = (mode == 3) ? 32'h0000CAFE : 32'hDEADBEEF;
      if (mode == 3 && cyc == 11) check({tag, "_mthi_busy"}, {32'd0, hi}, 64'h0000CAFE);
      if (cyc == 32) check({tag, "_fix_state"}, {62'd0, dbg_state}, 64'd3);
    end
    startE = 1'b0; mthiW = 1'b0; mtloW = 1'b0;
    check({tag, "_latency"}, cyc, 64'd33);
    check_result({tag, "_result"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_cnt;
    bit done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b0; startE = 1'b1; opE = 2'b00; srcaE = 32'd5; srcbE = 32'd5;
    mthiW = 1'b0; mtloW = 1'b0; wdataW = 32'd0; mdreqD = 1'b0;
    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_stall", {63'd0, mdstallD}, 64'd0);
    @(negedge clk);
    reset = 1'b1; startE = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 0, "multu_max");
    run_op(2'b01, 32'hFFFFFFF9, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFEB}, 0, "mult_neg");
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, "div_neg");
    run_op(2'b10, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF}, 0, "divu_zero");
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 0, "div_ovf");
    run_op(2'b11, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF}, 0, "div_zero_neg");
    run_op(2'b00, 32'd12345, 32'd678, model(2'b00, 32'd12345, 32'd678), 1, "multu_ignore");

    @(negedge clk);
    mtloW = 1'b1; wdataW = 32'h00001234;
    @(posedge clk); #1;
    mtloW = 1'b0;
    check("mtlo_idle", {hi, lo}, {last_exp[63:32], 32'h00001234});

    run_op(2'b00, 32'd2, 32'd3, 64'd6, 2, "multu_fix_mtlo");
    run_op(2'b01, 32'h00010000, 32'hFFFF0000, model(2'b01, 32'h00010000, 32'hFFFF0000), 3, "mult_mthi");

    @(negedge clk);
    startE = 1'b1; mdreqD = 1'b1; opE = 2'b01; srcaE = 32'h40000001; srcbE = 32'd4;
    exp_q.push_back({32'd1, 32'd4});
    stall_cnt = 0;
    done = 1'b0;
    while (!done && stall_cnt < 40) begin
      #1;
      if (mdstallD) begin
        stall_cnt++;
        @(posedge clk); #1;
        startE = 1'b0;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    startE = 1'b0;
    check("stall_cycles", stall_cnt, 64'd34);
    check("stall_release_busy", {63'd0, busy}, 64'd0);
    check_result("stall_result");
    mdreqD = 1'b0;

    @(negedge clk);
    startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd7;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b00, 32'd6, 32'd7, 64'd42, 0, "multu_after_reset");

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), 0, "rand");
    end

    check("queue_empty", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
